// File: rtl/fifo_pkg.sv
// Shared constants for the synchronous FIFO controller and its pointer sub-block.
package fifo_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int ADDR_WIDTH_DEF = 9;
  localparam int DEPTH          = 2 ** ADDR_WIDTH_DEF;
  localparam int CNT_WIDTH      = ADDR_WIDTH_DEF + 1;

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping RAM address pointer: advances by one per inc and rolls over
// from DEPTH-1 back to 0.
module fifo_ptr
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inc,
  output logic [ADDR_WIDTH-1:0] ptr
);

  logic [ADDR_WIDTH-1:0] r_ptr;

  // Pointer register; the all-ones address is the last RAM word, so it wraps to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (inc) begin
      if (&r_ptr) begin
        r_ptr <= '0;
      end else begin
        r_ptr <= r_ptr + ADDR_WIDTH'(1);
      end
    end
  end

  assign ptr = r_ptr;

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Synchronous FIFO controller driving an external dual-port RAM with a
// one-cycle registered read. Occupancy is tracked in a registered counter
// and every status flag is decoded from that counter alone.
//
// Request semantics: wr_en / rd_en are requests, and the registered
// full / empty flags act as the ready signals. A write is accepted
// exactly when wr_en=1 and full=0; a read exactly when rd_en=1 and
// empty=0. A request made while not ready is dropped (no retry is
// implied) and only raises the matching sticky error flag. Read data is
// qualified by rd_valid one cycle after the accepted read.
module sync_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int AF_LEVEL   = (2 ** ADDR_WIDTH) - 4,
  parameter int AE_LEVEL   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  ram_w_en,
  output logic [ADDR_WIDTH-1:0] ram_w_addr,
  output logic [DATA_WIDTH-1:0] ram_w_data,
  output logic                  ram_r_en,
  output logic [ADDR_WIDTH-1:0] ram_r_addr,
  input  logic [DATA_WIDTH-1:0] ram_r_data
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] LP_DEPTH = CW'(2 ** ADDR_WIDTH);
  localparam logic [CW-1:0] LP_AF    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] LP_AE    = CW'(AE_LEVEL);

  logic [CW-1:0]         r_count;
  logic                  r_rd_valid;
  logic                  r_overflow;
  logic                  r_underflow;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic [ADDR_WIDTH-1:0] w_wptr;
  logic [ADDR_WIDTH-1:0] w_rptr;

  // Acceptance uses only the registered flags, so when full a simultaneous
  // read wins and when empty a simultaneous write wins (no fall-through).
  // Reset suppresses both so the RAM sees no strobes while rst is high.
  assign w_wr_acc = wr_en & ~full  & ~rst;
  assign w_rd_acc = rd_en & ~empty & ~rst;

  fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_wptr (
    .clk (clk),
    .rst (rst),
    .inc (w_wr_acc),
    .ptr (w_wptr)
  );

  fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_rptr (
    .clk (clk),
    .rst (rst),
    .inc (w_rd_acc),
    .ptr (w_rptr)
  );

  // Occupancy counter: +1 write only, -1 read only, hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else begin
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Read-data qualifier tracks the RAM's one-cycle read latency; reset drops
  // any read that was in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_acc;
    end
  end

  // Sticky error flags: set by any request made against a blocking flag,
  // cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (wr_en && full) begin
        r_overflow <= 1'b1;
      end
      if (rd_en && empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign full         = (r_count == LP_DEPTH);
  assign empty        = (r_count == '0);
  assign almost_full  = (r_count >= LP_AF);
  assign almost_empty = (r_count <= LP_AE);
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;
  assign rd_valid     = r_rd_valid;
  assign rd_data      = ram_r_data;

  assign ram_w_en     = w_wr_acc;
  assign ram_w_addr   = w_wptr;
  assign ram_w_data   = wr_data;
  assign ram_r_en     = w_rd_acc;
  assign ram_r_addr   = w_rptr;

endmodule

// File: doc/sync_fifo_ctrl.md
SYNC_FIFO_CTRL -- requirements
Module: sync_fifo_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, the width of the data word.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 9, the RAM address width; DEPTH = 2**ADDR_WIDTH (512).
REQ-003 The block SHALL have parameter AF_LEVEL, default DEPTH-4, the almost-full threshold.
REQ-004 The block SHALL have parameter AE_LEVEL, default 4, the almost-empty threshold.
REQ-005 The block SHALL use one clock and a synchronous, active-high reset; ports clk and rst are listed first below.
REQ-006 clk  in  1  single clock; all state changes on its rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 wr_en  in  1  write request.
REQ-009 wr_data  in  DATA_WIDTH  write word.
REQ-010 rd_en  in  1  read request.
REQ-011 rd_data  out  DATA_WIDTH  read word; valid when rd_valid=1.
REQ-012 rd_valid  out  1  rd_data qualifier.
REQ-013 full, empty, almost_full, almost_empty  out  1 each  status flags.
REQ-014 count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
REQ-015 overflow, underflow  out  1 each  sticky error flags.
REQ-016 ram_w_en, ram_w_addr[ADDR_WIDTH], ram_w_data[DATA_WIDTH]  out  write port to external dp_ram (w_clk = r_clk = clk).
REQ-017 ram_r_en, ram_r_addr[ADDR_WIDTH]  out  read port to dp_ram; ram_r_data[DATA_WIDTH]  in  registered RAM read word.

Function
REQ-018 A write SHALL be accepted iff wr_en=1 and full=0; an accepted write drives ram_w_en=1, ram_w_addr=wptr and ram_w_data=wr_data in the same cycle, combinationally.
REQ-019 A read SHALL be accepted iff rd_en=1 and empty=0; an accepted read drives ram_r_en=1 and ram_r_addr=rptr in the same cycle.
REQ-020 wptr and rptr SHALL advance by 1 on each accepted access and wrap from DEPTH-1 to 0.
REQ-021 count SHALL update as +1 (write only), -1 (read only), or unchanged (both accepted, or neither).
REQ-022 Flags SHALL be decoded only from registered count: full=(count==DEPTH), empty=(count==0), almost_full=(count>=AF_LEVEL), almost_empty=(count<=AE_LEVEL); there is no path from wr_en/rd_en to any flag.
REQ-023 When full and both wr_en and rd_en are asserted, the read SHALL be accepted, the write rejected, and count decremented.
REQ-024 When empty and both wr_en and rd_en are asserted, the write SHALL be accepted, the read rejected (no fall-through), and count incremented.
REQ-025 rd_valid SHALL assert exactly one cycle after an accepted read; rd_data SHALL equal ram_r_data (1-cycle RAM latency).
REQ-026 overflow SHALL set on wr_en=1 while full=1, and underflow SHALL set on rd_en=1 while empty=1; both hold until rst.
REQ-027 Rejected requests SHALL leave the pointers, count and RAM unchanged.

Reset
REQ-028 While rst=1 at a clock edge: wptr=0, rptr=0, count=0, rd_valid=0, overflow=0, underflow=0.
REQ-029 After reset: empty=1, almost_empty=1, full=0, almost_full=0; ram_w_en=0 and ram_r_en=0 while rst=1.
REQ-030 rst asserted mid-operation SHALL discard all contents; a read in flight SHALL NOT produce rd_valid in the cycle after reset.

Structure
REQ-031 Package fifo_pkg SHALL hold the DATA_WIDTH and ADDR_WIDTH defaults, DEPTH, and the count width constant.
REQ-032 The wrapping pointer SHALL be one sub-module, fifo_ptr (inputs clk, rst, inc; output ptr), instantiated twice.
REQ-033 dp_ram SHALL stay outside this block and be connected at the parent level.

Verification
REQ-034 Reset, then 512 writes of values 0..511 mod 256 -> full=1 after the 512th write, count=512, almost_full from count=508; the 513th write sets overflow and leaves the RAM untouched.
REQ-035 Then 512 reads -> rd_valid one cycle after each read, data 0,1,2,... in order, empty=1 at the end; one more rd_en sets underflow.
REQ-036 At count=512, assert wr_en and rd_en together -> read accepted, write rejected, count=511.
REQ-037 At count=0, assert wr_en and rd_en together -> write accepted, no rd_valid, count=1.
REQ-038 Wrap test: fill 300, drain 300, fill 300 -> ram_w_addr wraps from 511 to 0 and the read data stays in order.
REQ-039 Assert rst with a read in flight at count=10 -> count=0, empty=1, rd_valid=0 on the next cycle, sticky flags cleared.
